// File: rtl/mips_periph_pkg.sv
// Register offsets and bit positions shared by the MIPS memory-mapped peripherals.
package mips_periph_pkg;

  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_LOAD   = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;
  localparam logic [1:0] TMR_STATUS = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_AR      = 1;
  localparam int CTRL_IE      = 2;
  localparam int CTRL_PRE_LSB = 8;

  localparam int STATUS_EXP = 0;

endpackage

// File: rtl/mips_timer_prescaler.sv
// Prescaler for the countdown timer: emits one tick every PRE+1 enabled cycles.
module mips_timer_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] pre,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q;
  logic [PRE_W-1:0] cnt_d;

  // A clear (CTRL write) suppresses the tick so new settings start from a clean period.
  assign tick = en && !clr && (cnt_q == pre);

  always_comb begin
    cnt_d = cnt_q + PRE_W'(1);
    if (!en || clr || (cnt_q == pre)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mips_timer.sv
// Memory-mapped countdown timer for the single-cycle MIPS data port: prescaler,
// one-shot or auto-reload countdown, sticky expiry flag and level interrupt.
module mips_timer
  import mips_periph_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PRE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic             en_q, en_d;
  logic             ar_q, ar_d;
  logic             ie_q, ie_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             exp_q, exp_d;

  logic       wr;
  logic [1:0] idx;
  logic       tick;
  logic       unused_bits;

  assign wr          = sel && we;
  assign idx         = addr[3:2];
  assign unused_bits = ^{addr[1:0], wdata};

  mips_timer_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en_q),
    .clr   (wr && (idx == TMR_CTRL)),
    .pre   (pre_q),
    .tick  (tick)
  );

  always_comb begin
    en_d    = en_q;
    ar_d    = ar_q;
    ie_d    = ie_q;
    pre_d   = pre_q;
    load_d  = load_q;
    count_d = count_q;
    exp_d   = exp_q;

    // W1C is applied before the countdown so a same-cycle expiry still sets EXP.
    if (wr && (idx == TMR_STATUS) && wdata[STATUS_EXP]) begin
      exp_d = 1'b0;
    end

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        exp_d = 1'b1;
        if (ar_q) begin
          count_d = load_q;
        end else begin
          en_d = 1'b0;
        end
      end
    end

    // CPU writes to CTRL/LOAD/COUNT override any countdown update this cycle.
    if (wr) begin
      case (idx)
        TMR_CTRL: begin
          en_d  = wdata[CTRL_EN];
          ar_d  = wdata[CTRL_AR];
          ie_d  = wdata[CTRL_IE];
          pre_d = wdata[CTRL_PRE_LSB +: PRE_W];
        end
        TMR_LOAD:  load_d  = wdata[CNT_W-1:0];
        TMR_COUNT: count_d = wdata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      ie_q    <= 1'b0;
      pre_q   <= '0;
      load_q  <= '0;
      count_q <= '0;
      exp_q   <= 1'b0;
    end else begin
      en_q    <= en_d;
      ar_q    <= ar_d;
      ie_q    <= ie_d;
      pre_q   <= pre_d;
      load_q  <= load_d;
      count_q <= count_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (idx)
        TMR_CTRL: begin
          rdata[CTRL_EN]                  = en_q;
          rdata[CTRL_AR]                  = ar_q;
          rdata[CTRL_IE]                  = ie_q;
          rdata[CTRL_PRE_LSB +: PRE_W]    = pre_q;
        end
        TMR_LOAD:   rdata[CNT_W-1:0]  = load_q;
        TMR_COUNT:  rdata[CNT_W-1:0]  = count_q;
        TMR_STATUS: rdata[STATUS_EXP] = exp_q;
        default: ;
      endcase
    end
  end

  assign irq = exp_q & ie_q;

endmodule

// File: tb/tb_mips_timer.sv
// Directed self-checking bench for mips_timer with hand-computed expectations.
module tb_mips_timer;

  localparam logic [1:0] R_CTRL   = 2'd0;
  localparam logic [1:0] R_LOAD   = 2'd1;
  localparam logic [1:0] R_COUNT  = 2'd2;
  localparam logic [1:0] R_STATUS = 2'd3;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_cmp;
  int n_err;

  mips_timer dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
    $display("[%0t] check %s observed=%h expected=%h", $time, tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = {r, 2'b00};
    wdata = d;
    step();
    sel   = 1'b0;
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic chk_reg(input logic [1:0] r, input logic [31:0] expv, input string tag);
    sel  = 1'b1;
    we   = 1'b0;
    addr = {r, 2'b00};
    #1;
    chk(tag, rdata, expv);
  endtask

  task automatic chk_irq(input logic expv, input string tag);
    chk(tag, {31'b0, irq}, {31'b0, expv});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    sel   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;

    // Reset then read
    repeat (3) step();
    reset = 1'b1;
    chk_reg(R_CTRL,   32'h0, "rst_ctrl");
    chk_reg(R_LOAD,   32'h0, "rst_load");
    chk_reg(R_COUNT,  32'h0, "rst_count");
    chk_reg(R_STATUS, 32'h0, "rst_status");
    chk_irq(1'b0, "rst_irq");

    // One-shot, PRE=0
    wr(R_COUNT, 32'd3);
    wr(R_CTRL, 32'h5);
    chk_reg(R_COUNT, 32'd3, "os_count_c0");
    step(); chk_reg(R_COUNT, 32'd2, "os_count_c1");
    step(); chk_reg(R_COUNT, 32'd1, "os_count_c2");
    step(); chk_reg(R_COUNT, 32'd0, "os_count_c3");
    chk_reg(R_STATUS, 32'h0, "os_exp_c3");
    chk_irq(1'b0, "os_irq_c3");
    step();
    chk_reg(R_STATUS, 32'h1, "os_exp_c4");
    chk_irq(1'b1, "os_irq_c4");
    chk_reg(R_CTRL, 32'h4, "os_ctrl_en_off");
    step();
    chk_reg(R_COUNT, 32'd0, "os_count_hold");
    chk_reg(R_STATUS, 32'h1, "os_exp_sticky");
    sel = 1'b0;
    #1;
    chk("sel0_rdata", rdata, 32'h0);
    wr(R_STATUS, 32'h1);
    chk_reg(R_STATUS, 32'h0, "os_w1c");
    chk_irq(1'b0, "os_irq_cleared");

    // Enabling with COUNT=0 expires on the first tick
    wr(R_CTRL, 32'h5);
    chk_reg(R_STATUS, 32'h0, "z_exp_before");
    step();
    chk_reg(R_STATUS, 32'h1, "z_exp_first_tick");
    chk_reg(R_CTRL, 32'h4, "z_ctrl_en_off");
    wr(R_STATUS, 32'h1);

    // Auto-reload with PRE=3: COUNT 2,1,0 each held 4 cycles, expiry every 12
    wr(R_LOAD, 32'd2);
    wr(R_COUNT, 32'd2);
    wr(R_CTRL, 32'h0000_0303);
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) step();
      chk_reg(R_COUNT, (i < 4) ? 32'd2 : (i < 8) ? 32'd1 : (i < 12) ? 32'd0 : 32'd2,
              $sformatf("ar_count_%0d", i));
      if (i >= 11) chk_reg(R_STATUS, (i == 12) ? 32'h1 : 32'h0, $sformatf("ar_exp_%0d", i));
    end
    chk_reg(R_CTRL, 32'h0000_0303, "ar_ctrl_en_stays");
    chk_irq(1'b0, "ar_irq_ie0");

    // W1C in a non-expiry cycle clears; W1C in the expiry cycle loses to the set
    wr(R_STATUS, 32'h1);
    chk_reg(R_STATUS, 32'h0, "w1c_clear");
    repeat (10) step();
    chk_reg(R_COUNT, 32'd0, "w1c_pre_count");
    chk_reg(R_STATUS, 32'h0, "w1c_pre_exp");
    wr(R_STATUS, 32'h1);
    chk_reg(R_STATUS, 32'h1, "w1c_vs_set");
    chk_reg(R_COUNT, 32'd2, "w1c_reload");

    // Write/tick collision on COUNT
    wr(R_CTRL, 32'h0);
    wr(R_STATUS, 32'h1);
    wr(R_COUNT, 32'd10);
    wr(R_CTRL, 32'h1);
    chk_reg(R_COUNT, 32'd10, "col_count10");
    wr(R_COUNT, 32'h100);
    chk_reg(R_COUNT, 32'h100, "col_write_wins");
    step();
    chk_reg(R_COUNT, 32'hFF, "col_then_dec");

    // Mid-operation asynchronous reset
    wr(R_CTRL, 32'h0);
    wr(R_LOAD, 32'd5);
    wr(R_COUNT, 32'd5);
    wr(R_CTRL, 32'h3);
    step();
    step();
    chk_reg(R_COUNT, 32'd3, "mr_count3");
    #2;
    reset = 1'b0;
    #1;
    chk_reg(R_CTRL,   32'h0, "mr_ctrl");
    chk_reg(R_LOAD,   32'h0, "mr_load");
    chk_reg(R_COUNT,  32'h0, "mr_count");
    chk_reg(R_STATUS, 32'h0, "mr_status");
    step();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_reg(R_COUNT, 32'h0, $sformatf("mr_idle_count_%0d", i));
      chk_reg(R_STATUS, 32'h0, $sformatf("mr_idle_exp_%0d", i));
    end
    chk_irq(1'b0, "mr_irq");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_timer.md
Name: mips_timer

Overview:
- Memory-mapped countdown timer peripheral on the data-memory port of the single-cycle MIPS CPU.
- Consumes the CPU's memaddr, memwrite and memwritedata; the system address decoder supplies a chip-select.
- Returns read data combinationally in the same cycle, because the CPU has no load stall.
- Provides a programmable prescaler, one-shot or auto-reload countdown, a sticky expiry flag and a level interrupt.

Parameters:
- CNT_W, 32: countdown counter width, 1..32. Reads zero-extend to 32 bits.
- PRE_W, 8: prescaler width, 1..8. Lives in CTRL[8+PRE_W-1:8].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low (0 = reset).
- sel  input  1  chip select from the system address decoder.
- we  input  1  write strobe (CPU memwrite); a write is acted on only when sel=1.
- addr  input  4  memaddr[3:0]; addr[3:2] selects the register, addr[1:0] is ignored.
- wdata  input  32  CPU memwritedata.
- rdata  output  32  read data; combinational.
- irq  output  1  level interrupt = STATUS.EXP & CTRL.IE.

Behaviour:
- Register map (word offsets):
  - 0x0 CTRL: bit0 EN, bit1 AR (auto-reload), bit2 IE, bits[8+PRE_W-1:8] PRE. Other bits read 0.
  - 0x4 LOAD: reload value, read/write.
  - 0x8 COUNT: current count. Reads the current value; a write loads COUNT directly.
  - 0xC STATUS: bit0 EXP, sticky. Writing 1 to bit0 clears it; writing 0 has no effect.
- Reset (reset=0, asynchronous): CTRL=0, LOAD=0, COUNT=0, EXP=0, prescaler=0, irq=0.
- rdata:
  - sel=0: 0.
  - sel=1: the selected register, combinational from the current state, independent of we.
- Prescaler:
  - Counts 0..PRE only while EN=1. tick=1 in the cycle where prescaler==PRE; the prescaler then returns to 0.
  - PRE=0 gives a tick every cycle; the tick period is PRE+1 cycles.
  - When EN=0 the prescaler is held at 0.
- On tick, if COUNT!=0: COUNT <= COUNT-1.
- On tick, if COUNT==0:
  - EXP <= 1.
  - AR=1: COUNT <= LOAD and EN stays 1.
  - AR=0: COUNT stays 0 and EN <= 0 (one-shot).
- Auto-reload period = (LOAD+1)*(PRE+1) cycles.
- Simultaneous events, same cycle:
  - CPU write to COUNT and tick: the write wins and no decrement occurs.
  - CPU write to CTRL: the prescaler is cleared to 0 and no tick is taken that cycle.
  - CPU write to CTRL with EN=0 in the same cycle as a one-shot expiry: the written value wins.
  - W1C to EXP and expiry: the set wins, so EXP=1.
  - Write to LOAD and reload: the reload uses the old LOAD.
- Writes to LOAD never touch COUNT.
- Writing LOAD or COUNT with values wider than CNT_W: upper bits are truncated.
- Enabling with COUNT=0: the first tick sets EXP immediately.
- reset asserted mid-count: all state returns to reset values immediately. Counting resumes only after software sets EN again.
- irq is a pure function of registered state and has no extra latency beyond EXP.

Decomposition:
- Shared package mips_periph_pkg holds:
  - register offsets TMR_CTRL=2'd0, TMR_LOAD=2'd1, TMR_COUNT=2'd2, TMR_STATUS=2'd3;
  - CTRL bit positions EN=0, AR=1, IE=2, PRE_LSB=8;
  - STATUS_EXP=0.
- One sub-module, mips_timer_prescaler: inputs clk, reset, en, clr, pre; outputs tick. It contains the PRE_W counter and tick generation.
- Register file, countdown logic and read mux stay in mips_timer.

Test Plan:
- Reset then read: reset=0 for 3 cycles, release, read all four offsets with sel=1 -> each returns 0x00000000; irq=0; rdata=0 whenever sel=0.
- One-shot, PRE=0: write COUNT=3, then CTRL=0x5 (EN, IE) -> COUNT reads 2,1,0 on the next 3 cycles. EXP=1 and irq=1 on the 4th cycle after the CTRL write; EN reads 0; COUNT holds 0.
- Auto-reload with prescaler: LOAD=2, COUNT=2, CTRL=0x0000_0303 (EN, AR, PRE=3) -> EXP sets every 12 cycles. COUNT follows 2,1,0,2 with each value held 4 cycles. EN stays 1.
- W1C vs set: clear EXP by writing STATUS=1 in a non-expiry cycle -> EXP=0 next cycle. Write STATUS=1 in the exact expiry cycle -> EXP remains 1.
- Write/tick collision: PRE=0, counting down at COUNT=10, write COUNT=0x100 -> next cycle reads 0x100, not 9. The following cycle reads 0xFF.
- Mid-operation reset: LOAD=5, AR=1, EN=1, counting; assert reset at COUNT=3 -> all registers read 0 in the same cycle, asynchronously. After release, COUNT stays 0 and EXP stays 0 for 20 cycles.
